// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - bus widths, default depth and entry type for inst_queue (INST_QUEUE_BYPASS_EN selects bypass)
`ifndef NPC_ADDR_BUS
`define NPC_ADDR_BUS 31:0
`endif
`ifndef NPC_DATA_BUS
`define NPC_DATA_BUS 31:0
`endif
`ifndef INST_QUEUE_DEPTH
`define INST_QUEUE_DEPTH 4
`endif

package inst_queue_pkg;

  localparam int IQ_DEFAULT_DEPTH = `INST_QUEUE_DEPTH;

  typedef struct packed {
    logic [`NPC_ADDR_BUS] pc;
    logic [`NPC_DATA_BUS] inst;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - DEPTH x {pc, inst} storage, one write port, one asynchronous read port, no reset
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  iq_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output iq_entry_t        rdata_o
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue with flush; INST_QUEUE_BYPASS_EN adds empty-queue bypass
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 valid_pre_i,
  output logic                 ready_pre_o,
  input  logic [`NPC_ADDR_BUS] pc_i,
  input  logic [`NPC_DATA_BUS] inst_i,
  output logic                 valid_post_o,
  input  logic                 ready_post_i,
  output logic [`NPC_ADDR_BUS] pc_o,
  output logic [`NPC_DATA_BUS] inst_o,
  output logic [PTR_W:0]       count_o
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic      push, pop, head_valid, bypass;
  iq_entry_t in_entry, head_entry, out_entry;

  assign in_entry = '{pc: pc_i, inst: inst_i};

  inst_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    // Full blocks input even if decode pops this cycle: ready stays purely count-based.
    ready_pre_o = ~reset & (count_q != FULL_CNT);
    head_valid  = ~reset & ~flush_i & (count_q != '0);
`ifdef INST_QUEUE_BYPASS_EN
    bypass      = ~reset & ~flush_i & valid_pre_i & (count_q == '0);
`else
    bypass      = 1'b0;
`endif
    valid_post_o = head_valid | bypass;
    pop          = head_valid & ready_post_i;
    // A bypassed beat consumed by decode never touches storage.
    push         = valid_pre_i & ready_pre_o & ~flush_i & ~(bypass & ready_post_i);

    out_entry = bypass ? in_entry : head_entry;
    pc_o      = valid_post_o ? out_entry.pc   : '0;
    inst_o    = valid_post_o ? out_entry.inst : '0;
    count_o   = reset ? '0 : count_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue (INST_QUEUE_BYPASS_EN selects bypass expectations)
module tb_inst_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        valid_post_o;
  logic        ready_post_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [2:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  inst_queue dut (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (flush_i),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .count_o      (count_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic vp, input logic [31:0] pc, input logic rp, input logic fl);
    valid_pre_i  = vp;
    pc_i         = pc;
    inst_i       = pc ^ 32'h0000_0013;
    ready_post_i = rp;
    flush_i      = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    // 1. reset for 3 cycles, then idle
    tick(); tick();
    chk("rst_ready", 32'(ready_pre_o), 32'd0);
    chk("rst_valid", 32'(valid_post_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("idle_ready", 32'(ready_pre_o), 32'd1);
    chk("idle_valid", 32'(valid_post_o), 32'd0);
    chk("idle_count", 32'(count_o), 32'd0);
    chk("idle_pc", pc_o, 32'h0);

    // 2. fill to full with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
      chk("fill_ready", 32'(ready_pre_o), 32'd1);
      chk("fill_count", 32'(count_o), 32'(i));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("full_ready", 32'(ready_pre_o), 32'd0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_head_pc", pc_o, 32'h8000_0000);
    chk("full_head_inst", inst_o, 32'h8000_0013);
    tick();
    chk("stall_head_pc", pc_o, 32'h8000_0000);
    chk("stall_valid", 32'(valid_post_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_valid", 32'(valid_post_o), 32'd1);
      chk("drain_pc", pc_o, 32'h8000_0000 + 32'(4 * k));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drained_count", 32'(count_o), 32'd0);
    chk("drained_valid", 32'(valid_post_o), 32'd0);

    // 3. 20-beat stream with both sides always ready
    for (int i = 0; i <= 20; i++) begin
      drive(i < 20, 32'h8000_1000 + 32'(4 * i), 1'b1, 1'b0);
`ifdef INST_QUEUE_BYPASS_EN
      chk("stream_count", 32'(count_o), 32'd0);
      chk("stream_valid", 32'(valid_post_o), (i < 20) ? 32'd1 : 32'd0);
      if (i < 20) chk("stream_pc", pc_o, 32'h8000_1000 + 32'(4 * i));
`else
      chk("stream_count", 32'(count_o), (i == 0) ? 32'd0 : 32'd1);
      chk("stream_valid", 32'(valid_post_o), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("stream_pc", pc_o, 32'h8000_1000 + 32'(4 * (i - 1)));
`endif
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stream_end_count", 32'(count_o), 32'd0);

    // 4. flush with 3 entries and a same-cycle input beat
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h8000_0100, 1'b0, 1'b1);
    chk("flush_valid", 32'(valid_post_o), 32'd0);
    chk("flush_pc", pc_o, 32'h0);
    chk("flush_ready", 32'(ready_pre_o), 32'd1);
    chk("flush_count_now", 32'(count_o), 32'd3);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_flush_count", 32'(count_o), 32'd0);
    chk("post_flush_valid", 32'(valid_post_o), 32'd0);
    drive(1'b1, 32'h8000_0300, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_flush_head", pc_o, 32'h8000_0300);
    chk("post_flush_cnt1", 32'(count_o), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_flush_empty", 32'(count_o), 32'd0);

    // 5. full queue: simultaneous pop and offered input -> pop only
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0400 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h8000_0410, 1'b1, 1'b0);
    chk("fullpop_ready", 32'(ready_pre_o), 32'd0);
    chk("fullpop_count", 32'(count_o), 32'd4);
    chk("fullpop_pc", pc_o, 32'h8000_0400);
    tick();
    drive(1'b1, 32'h8000_0410, 1'b0, 1'b0);
    chk("after_pop_count", 32'(count_o), 32'd3);
    chk("after_pop_ready", 32'(ready_pre_o), 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      if (k == 0) chk("refill_count", 32'(count_o), 32'd4);
      chk("fullpop_drain_pc", pc_o, 32'h8000_0404 + 32'(4 * k));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fullpop_empty", 32'(count_o), 32'd0);

    // reset in the middle of operation drops entries
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h8000_0500 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 32'h8000_0600, 1'b1, 1'b0);
    chk("midrst_ready", 32'(ready_pre_o), 32'd0);
    chk("midrst_valid", 32'(valid_post_o), 32'd0);
    chk("midrst_count", 32'(count_o), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("midrst_after_count", 32'(count_o), 32'd0);
    chk("midrst_after_valid", 32'(valid_post_o), 32'd0);

    // 6. single beat into an empty queue with decode ready
    drive(1'b1, 32'h8000_0020, 1'b1, 1'b0);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_valid", 32'(valid_post_o), 32'd1);
    chk("byp_pc", pc_o, 32'h8000_0020);
    chk("byp_count", 32'(count_o), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_after_count", 32'(count_o), 32'd0);
    chk("byp_after_valid", 32'(valid_post_o), 32'd0);
`else
    chk("nobyp_valid", 32'(valid_post_o), 32'd0);
    chk("nobyp_pc", pc_o, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("nobyp_next_valid", 32'(valid_post_o), 32'd1);
    chk("nobyp_next_pc", pc_o, 32'h8000_0020);
    chk("nobyp_next_count", 32'(count_o), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("nobyp_after_count", 32'(count_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
